// File: rtl/abh_unit.sv
// rtl/abh_unit.sv - Address-bus-high stage: ADH select, ABH/PCH registers, deferred page-cross carry.
module abh_unit (
    input  logic       clk,
    input  logic       RST,
    input  logic       rdy,
    input  logic       CI,
    input  logic       pcl_co,
    input  logic       bsign,
    input  logic [7:0] DB,
    input  logic [2:0] op,
    input  logic       defer,
    input  logic       ld_ahh,
    input  logic       ld_pc,
    input  logic       inc_pc,
    output logic [7:0] ADH,
    output logic [7:0] ABH,
    output logic [7:0] PCH,
    output logic       fixup
);

    typedef enum logic [2:0] {
        OP_STAY   = 3'b000,
        OP_PC     = 3'b001,
        OP_INDEX  = 3'b010,
        OP_DB     = 3'b011,
        OP_ZP     = 3'b100,
        OP_STACK  = 3'b101,
        OP_VECTOR = 3'b110,
        OP_BRANCH = 3'b111
    } adh_op_t;

    logic [7:0] ahh;
    logic       pend;
    logic       c;
    logic       pend_set;
    logic [7:0] pc_inc;
    adh_op_t    op_sel;

    assign op_sel = adh_op_t'(op);
    assign c      = defer ? 1'b0 : CI;

    // The carry is withheld only when it would have rippled into the high byte
    // of an indexed/stay address; the next cycle then applies it as ABH+1.
    assign pend_set = !pend && defer && CI && ((op_sel == OP_STAY) || (op_sel == OP_INDEX));
    assign pc_inc   = {7'b0, inc_pc & pcl_co};

    always_comb begin
        ADH = 8'h00;
        if (pend) begin
            ADH = ABH + 8'h01;
        end else begin
            unique case (op_sel)
                OP_STAY:   ADH = ABH + {7'b0, c};
                OP_PC:     ADH = PCH;
                OP_INDEX:  ADH = ahh + {7'b0, c};
                OP_DB:     ADH = DB + {7'b0, c};
                OP_ZP:     ADH = 8'h00;
                OP_STACK:  ADH = 8'h01;
                OP_VECTOR: ADH = 8'hFF;
                OP_BRANCH: ADH = ABH + {8{bsign}} + {7'b0, CI};
                default:   ADH = 8'h00;
            endcase
        end
    end

    // PCH samples the current ABH, so a load during fixup sees the pre-fixup page.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ahh  <= 8'h00;
            ABH  <= 8'h00;
            PCH  <= 8'h00;
            pend <= 1'b0;
        end else if (rdy) begin
            if (ld_ahh) begin
                ahh <= DB;
            end
            if (ld_pc) begin
                PCH <= ABH + pc_inc;
            end
            ABH  <= ADH;
            pend <= pend_set;
        end
    end

    assign fixup = pend;

endmodule

// File: tb/tb_abh_unit.sv
// tb/tb_abh_unit.sv - Directed self-checking bench for abh_unit.
module tb_abh_unit;

    logic       clk = 1'b0;
    logic       RST;
    logic       rdy;
    logic       CI;
    logic       pcl_co;
    logic       bsign;
    logic [7:0] DB;
    logic [2:0] op;
    logic       defer;
    logic       ld_ahh;
    logic       ld_pc;
    logic       inc_pc;
    logic [7:0] ADH;
    logic [7:0] ABH;
    logic [7:0] PCH;
    logic       fixup;

    int checks = 0;
    int errors = 0;

    abh_unit dut (
        .clk    (clk),
        .RST    (RST),
        .rdy    (rdy),
        .CI     (CI),
        .pcl_co (pcl_co),
        .bsign  (bsign),
        .DB     (DB),
        .op     (op),
        .defer  (defer),
        .ld_ahh (ld_ahh),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .ADH    (ADH),
        .ABH    (ABH),
        .PCH    (PCH),
        .fixup  (fixup)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        RST = 1'b1; rdy = 1'b0; CI = 1'b0; pcl_co = 1'b0; bsign = 1'b0;
        DB = 8'h00; op = 3'b000; defer = 1'b0; ld_ahh = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0;

        // Reset state, held across a clock edge
        @(posedge clk);
        #2;
        check("rst_abh", ABH, 8'h00);
        check("rst_pch", PCH, 8'h00);
        check("rst_fixup", {7'b0, fixup}, 8'h00);
        check("rst_adh", ADH, 8'h00);
        RST = 1'b0;

        // Load ahh=12, keep ABH on zero page
        rdy = 1'b1; ld_ahh = 1'b1; DB = 8'h12; op = 3'b100;
        step();
        ld_ahh = 1'b0;
        check("ahh_load_abh", ABH, 8'h00);

        // Absolute,X page cross with deferred carry
        op = 3'b010; defer = 1'b1; CI = 1'b1;
        settle();
        check("defer_adh", ADH, 8'h12);
        step();
        check("defer_abh", ABH, 8'h12);
        check("defer_fixup_set", {7'b0, fixup}, 8'h01);
        op = 3'b000; CI = 1'b0;
        settle();
        check("fixup_adh", ADH, 8'h13);
        step();
        check("fixup_abh", ABH, 8'h13);
        check("fixup_clear", {7'b0, fixup}, 8'h00);

        // Same with defer=0: single-cycle carry
        op = 3'b010; defer = 1'b0; CI = 1'b1;
        settle();
        check("nodefer_adh", ADH, 8'h13);
        step();
        check("nodefer_abh", ABH, 8'h13);
        check("nodefer_fixup", {7'b0, fixup}, 8'h00);

        // Branches from ABH=20
        op = 3'b011; DB = 8'h20; CI = 1'b0;
        step();
        check("db_abh", ABH, 8'h20);
        op = 3'b111; bsign = 1'b1; CI = 1'b0;
        settle();
        check("br_back_adh", ADH, 8'h1F);
        CI = 1'b1;
        settle();
        check("br_back_ci_adh", ADH, 8'h20);
        defer = 1'b1;
        settle();
        check("br_defer_adh", ADH, 8'h20);
        bsign = 1'b0;
        settle();
        check("br_fwd_adh", ADH, 8'h21);
        step();
        check("br_no_pend", {7'b0, fixup}, 8'h00);
        defer = 1'b0; CI = 1'b0;

        // PC wrap
        op = 3'b101;
        settle();
        check("stack_adh", ADH, 8'h01);
        op = 3'b110;
        step();
        check("vec_abh", ABH, 8'hFF);
        ld_pc = 1'b1; inc_pc = 1'b1; pcl_co = 1'b1;
        step();
        check("pc_wrap", PCH, 8'h00);
        pcl_co = 1'b0;
        step();
        check("pc_nowrap", PCH, 8'hFF);
        ld_pc = 1'b0;
        op = 3'b001;
        settle();
        check("restore_adh", ADH, 8'hFF);

        // rdy low during fixup holds everything
        op = 3'b010; defer = 1'b1; CI = 1'b1;
        step();
        check("hold_pre_abh", ABH, 8'h12);
        check("hold_pre_fixup", {7'b0, fixup}, 8'h01);
        rdy = 1'b0; ld_pc = 1'b1; inc_pc = 1'b0;
        step(); step(); step();
        check("hold_abh", ABH, 8'h12);
        check("hold_pch", PCH, 8'hFF);
        check("hold_fixup", {7'b0, fixup}, 8'h01);
        check("hold_adh", ADH, 8'h13);
        rdy = 1'b1; ld_pc = 1'b0;
        step();
        check("resume_abh", ABH, 8'h13);
        check("resume_fixup", {7'b0, fixup}, 8'h00);
        settle();
        check("repend_adh", ADH, 8'h12);
        step();
        check("repend_fixup", {7'b0, fixup}, 8'h01);

        // ld_pc during fixup takes pre-fixup ABH
        ld_pc = 1'b1; inc_pc = 1'b0;
        step();
        check("pc_prefix", PCH, 8'h12);
        check("pc_prefix_abh", ABH, 8'h13);
        ld_pc = 1'b0;
        step();
        check("pend_again", {7'b0, fixup}, 8'h01);

        // Asynchronous reset mid-fixup
        RST = 1'b1; op = 3'b110;
        settle();
        check("arst_abh", ABH, 8'h00);
        check("arst_pch", PCH, 8'h00);
        check("arst_fixup", {7'b0, fixup}, 8'h00);
        check("arst_adh", ADH, 8'hFF);
        RST = 1'b0;
        op = 3'b000; defer = 1'b0; CI = 1'b1;
        settle();
        check("post_adh", ADH, 8'h01);
        step();
        check("post_abh", ABH, 8'h01);
        check("post_fixup", {7'b0, fixup}, 8'h00);
        op = 3'b010; CI = 1'b0;
        settle();
        check("post_ahh_adh", ADH, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/abh_unit.md
ABH_UNIT -- requirements
Module: abh_unit

Interface
REQ-001 The block SHALL have the input clk, 1 bit, the single clock; all registers update on its rising edge.
REQ-002 The block SHALL have the input RST, 1 bit, an asynchronous active-high reset.
REQ-003 The block SHALL have the input rdy, 1 bit; when low, no register (ahh, abh, pch, pend) changes state.
REQ-004 The block SHALL have the input CI, 1 bit, the carry out of the address-low stage for the current cycle.
REQ-005 The block SHALL have the input pcl_co, 1 bit, the carry out of the PCL incrementer.
REQ-006 The block SHALL have the input bsign, 1 bit, the sign of the branch offset (DB[7] of the offset byte, held by the sequencer).
REQ-007 The block SHALL have the input DB, 8 bits, the data bus.
REQ-008 The block SHALL have the input op, 3 bits, which selects the high-byte operation.
REQ-009 The block SHALL have the input defer, 1 bit, the deferred-carry (page-cross penalty) mode enable.
REQ-010 The block SHALL have the inputs ld_ahh, ld_pc and inc_pc, 1 bit each, with the same meaning as the low-byte controls.
REQ-011 The block SHALL have the output ADH, 8 bits, the unregistered next address high.
REQ-012 The block SHALL have the output ABH, 8 bits, the registered address bus high.
REQ-013 The block SHALL have the output PCH, 8 bits, the program counter high.
REQ-014 The block SHALL have the output fixup, 1 bit, which is high while a deferred carry is pending.

Function
REQ-015 The block SHALL load ahh with DB on a clock edge when ld_ahh and rdy are both high.
REQ-016 The block SHALL form the effective carry c as CI when defer=0, and as 0 when defer=1.
REQ-017 When pend=1, ADH SHALL equal ABH+1 and op SHALL be ignored; when pend=0, ADH SHALL be selected by op as follows:
  - 000: ABH+c (stay or next)
  - 001: PCH (restore)
  - 010: ahh+c (absolute + index)
  - 011: DB+c (indirect pointer high)
  - 100: 8'h00 (zero page)
  - 101: 8'h01 (stack page)
  - 110: 8'hFF (vectors)
  - 111: ABH+{8{bsign}}+CI (branch); defer has no effect for this op.
REQ-018 All ADH sums SHALL be 8 bits with the carry out discarded, so 8'hFF+1 wraps to 8'h00.
REQ-019 The block SHALL load ABH with ADH on every clock edge on which rdy is high.
REQ-020 On an edge with rdy high, pend SHALL be set to 1 when pend=0, defer=1, CI=1 and op is 000 or 010, and SHALL be cleared to 0 otherwise.
REQ-021 A deferred cycle SHALL last exactly one cycle, and pend SHALL never be high for two consecutive enabled edges.
REQ-022 The block SHALL drive fixup directly from pend, registered with no combinational path from its inputs.
REQ-023 On an edge with ld_pc and rdy both high, PCH SHALL load ABH + (inc_pc & pcl_co), which wraps from 8'hFF to 8'h00.
REQ-024 When rdy is low, all state SHALL hold, including pend; ADH SHALL still follow its inputs combinationally.
REQ-025 If ld_pc and pend are high together, PCH SHALL use the pre-fixup ABH value; the sequencer SHALL not assert ld_pc during fixup.

Reset
REQ-026 While RST is high, ahh, ABH, PCH and pend SHALL be 0 and fixup SHALL be 0, regardless of clk and rdy.
REQ-027 When RST is asserted mid-fixup, pend SHALL clear immediately and no +1 SHALL be applied after release.
REQ-028 On the first enabled edge after RST deasserts, the block SHALL operate normally from the all-zero state.

Verification
REQ-029 Absolute,X page cross: ahh=8'h12, op=010, defer=1, CI=1 -> ADH=8'h12 and fixup=1 next cycle; with op=000, ADH=8'h13; then fixup=0.
REQ-030 Same case with defer=0 -> ADH=8'h13 in a single cycle and fixup stays 0.
REQ-031 Backward branch: ABH=8'h20, op=111, bsign=1, CI=0 -> ADH=8'h1F; with bsign=1 and CI=1 -> ADH=8'h20.
REQ-032 PC wrap: ABH=8'hFF, ld_pc=1, inc_pc=1, pcl_co=1 -> PCH=8'h00; with pcl_co=0 -> PCH=8'hFF.
REQ-033 rdy=0 for 3 cycles during pend=1 -> ABH, PCH and fixup hold; on the first edge with rdy=1, the fixup completes once.
REQ-034 RST pulsed asynchronously between clock edges with pend=1 -> all outputs read 0 before the next edge, and op=110 then gives ADH=8'hFF.
